// File: rtl/bshift_arbiter.sv
// bshift_arbiter: two requesters share a single combinational 8-bit rotator.
// A round-robin arbiter picks one requester per cycle. Its rotated operand is
// captured in a one-entry result register with valid/ready handshaking.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for requester N (N = 0,1)
//   reqN_a / reqN_amt / reqN_lr    operand, rotate amount 0-7, 1 = left / 0 = right
//   res_valid / res_ready          result handshake
//   res_y / res_id                 rotated result and the requester that produced it
//   cnt0 / cnt1                    per-requester grant counters (saturating)
//
// Build option
//   BSHIFT_ARBITER_STATS_EN  defined: cnt0/cnt1 count accepted transfers.
//                            undefined: cnt0/cnt1 are tied to zero.
module bshift_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [2:0] req0_amt,
  input  logic       req0_lr,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [2:0] req1_amt,
  input  logic       req1_lr,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic       res_id,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     r_state;
  logic       r_last;   // requester granted on the most recent accepted transfer
  logic [7:0] r_y;
  logic       r_id;

  logic       w_can_accept;
  logic       w_grant;
  logic       w_acc;
  logic [7:0] w_sel_a;
  logic [2:0] w_sel_amt;
  logic       w_sel_lr;
  logic [7:0] w_rot_in;
  logic [15:0] w_dbl;
  logic [7:0] w_rot_out;
  logic [7:0] w_y;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // The register can take new data when it is empty, or when it is
  // being drained in this same cycle. Nothing is accepted while in reset.
  assign w_can_accept = ((r_state == EMPTY) || res_ready) && !reset;

  // A tie goes to the requester that did not win last time. A lone requester
  // always wins. The grant depends only on valids and the pointer.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = ~r_last;
    else                          w_grant = req1_valid;
  end

  assign req0_ready = w_can_accept && req0_valid && (w_grant == 1'b0);
  assign req1_ready = w_can_accept && req1_valid && (w_grant == 1'b1);
  assign w_acc      = req0_ready || req1_ready;

  assign w_sel_a   = w_grant ? req1_a   : req0_a;
  assign w_sel_amt = w_grant ? req1_amt : req0_amt;
  assign w_sel_lr  = w_grant ? req1_lr  : req0_lr;

  // Shared rotator. It rotates right only; a left rotate is done by
  // reversing the bits, rotating right, then reversing again.
  assign w_rot_in  = w_sel_lr ? rev8(w_sel_a) : w_sel_a;
  assign w_dbl     = {w_rot_in, w_rot_in};
  assign w_rot_out = w_dbl[w_sel_amt +: 8];
  assign w_y       = w_sel_lr ? rev8(w_rot_out) : w_rot_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_y     <= 8'h00;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_state <= FULL;
            r_y     <= w_y;
            r_id    <= w_grant;
            r_last  <= w_grant;
          end
        end
        FULL: begin
          // A drain and an accept in the same cycle reload the register
          // and stay FULL, so no bubble is inserted.
          if (w_acc) begin
            r_y    <= w_y;
            r_id   <= w_grant;
            r_last <= w_grant;
          end else if (res_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign res_valid = (r_state == FULL);
  assign res_y     = r_y;
  assign res_id    = r_id;

`ifdef BSHIFT_ARBITER_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= 8'h00;
      r_cnt1 <= 8'h00;
    end else begin
      if (req0_ready && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
      if (req1_ready && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  assign cnt0 = 8'h00;
  assign cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_bshift_arbiter.sv
// Self-checking bench for bshift_arbiter.
// On each accepted request, the expected result {y,id} is pushed to a
// scoreboard queue. It is popped and compared when the DUT hands the result
// to the consumer.
module tb_bshift_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req0_lr;
  logic [7:0] req0_a;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_lr;
  logic [7:0] req1_a;
  logic [2:0] req1_amt;
  logic       res_valid, res_ready, res_id;
  logic [7:0] res_y, cnt0, cnt1;

  always #5 clk = ~clk;

  bshift_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_amt(req0_amt), .req0_lr(req0_lr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_amt(req1_amt), .req1_lr(req1_lr),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic last_gnt;
  int   nacc;

  // Bit-by-bit reference rotate.
  function automatic logic [7:0] model_rot(input logic [7:0] a, input logic [2:0] amt,
                                           input logic lr);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (lr) y[(i + int'(amt)) % 8] = a[i];
      else    y[i] = a[(i + int'(amt)) % 8];
    end
    return y;
  endfunction

  // Called just after a rising edge with inputs already set. It settles,
  // checks any result being consumed, records accepts, then advances one cycle.
  task automatic step();
    exp_t e;
    #1;
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got y=%h id=%0d, required no result", res_y, res_id);
      end else begin
        e = sb.pop_front();
        if (res_y !== e.y || res_id !== e.id) begin
          errors++;
          $display("FAIL sb_result: got y=%h id=%0d, required y=%h id=%0d",
                   res_y, res_id, e.y, e.id);
        end
      end
    end
    checks++;
    if (req0_ready && req1_ready) begin
      errors++;
      $display("FAIL one_ready: got both readys high, required at most one");
    end
    nacc = 0;
    if (req0_ready) begin
      e.y = model_rot(req0_a, req0_amt, req0_lr); e.id = 1'b0;
      sb.push_back(e); last_gnt = 1'b0; nacc++;
    end
    if (req1_ready) begin
      e.y = model_rot(req1_a, req1_amt, req1_lr); e.id = 1'b1;
      sb.push_back(e); last_gnt = 1'b1; nacc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || res_y !== 8'h00 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b y=%h id=%b, required v=0 y=00 id=0",
               res_valid, res_y, res_id);
    end
    checks++;
    if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_cnt: got %h/%h, required 00/00", cnt0, cnt1);
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    sb.delete();
  endtask

  // Sends one request, checks the held result, then drains it.
  task automatic one_req(input logic id, input logic [7:0] a, input logic [2:0] amt,
                         input logic lr, input logic [7:0] exp_y, input string nm);
    res_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_amt = amt; req1_lr = lr; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_amt = amt; req0_lr = lr; end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (nacc != 1 || res_valid !== 1'b1 || res_y !== exp_y || res_id !== id) begin
      errors++;
      $display("FAIL %s: got acc=%0d v=%b y=%h id=%b, required acc=1 v=1 y=%h id=%b",
               nm, nacc, res_valid, res_y, res_id, exp_y, id);
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got res_valid=%b, required 0", nm, res_valid);
    end
  endtask

  task automatic test_rotate();
    one_req(1'b0, 8'b1000_0001, 3'd1, 1'b1, 8'b0000_0011, "rot_left");
    one_req(1'b1, 8'hA5, 3'd4, 1'b0, 8'h5A, "rot_right");
    one_req(1'b0, 8'h3C, 3'd0, 1'b1, 8'h3C, "amt0_left");
    one_req(1'b1, 8'hC3, 3'd0, 1'b0, 8'hC3, "amt0_right");
    one_req(1'b1, 8'h01, 3'd7, 1'b0, 8'h02, "rot_right7");
  endtask

  task automatic test_alternate();
    do_reset();
    res_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = 8'($urandom); req0_amt = 3'($urandom); req0_lr = 1'($urandom);
      req1_a = 8'($urandom); req1_amt = 3'($urandom); req1_lr = 1'($urandom);
      step();
      checks++;
      if (nacc != 1 || last_gnt !== 1'(k % 2)) begin
        errors++;
        $display("FAIL alternate[%0d]: got acc=%0d grant=%0d, required acc=1 grant=%0d",
                 k, nacc, last_gnt, k % 2);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [7:0] hold_y;
    res_ready = 1'b1; req0_valid = 1'b1;
    req0_a = 8'h5E; req0_amt = 3'd3; req0_lr = 1'b0;
    hold_y = model_rot(8'h5E, 3'd3, 1'b0);
    step();
    res_ready = 1'b0; req1_valid = 1'b1;
    req0_a = 8'hFF; req1_a = 8'h12; req1_amt = 3'd2; req1_lr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (res_valid !== 1'b1 || res_y !== hold_y || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b y=%h id=%b rdy=%b%b, required v=1 y=%h id=0 rdy=00",
                 k, res_valid, res_y, res_id, req0_ready, req1_ready, hold_y);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got res_valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 80; k++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      req0_a = 8'($urandom); req0_amt = 3'($urandom); req0_lr = 1'($urandom);
      req1_a = 8'($urandom); req1_amt = 3'($urandom); req1_lr = 1'($urandom);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_full();
    res_ready = 1'b0; req0_valid = 1'b1;
    req0_a = 8'h77; req0_amt = 3'd1; req0_lr = 1'b1;
    step();
    req0_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_before_reset: got res_valid=%b, required 1", res_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_y !== 8'h00) begin
      errors++;
      $display("FAIL reset_full: got v=%b y=%h, required v=0 y=00", res_valid, res_y);
    end
    sb.delete();
    res_ready = 1'b1;
  endtask

  task automatic test_stats();
    logic [7:0] exp_c0;
`ifdef BSHIFT_ARBITER_STATS_EN
    exp_c0 = 8'hFF;
`else
    exp_c0 = 8'h00;
`endif
    do_reset();
    res_ready = 1'b1; req0_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      req0_a = 8'($urandom); req0_amt = 3'($urandom); req0_lr = 1'($urandom);
      step();
    end
    req0_valid = 1'b0;
    step();
    checks++;
    if (cnt0 !== exp_c0 || cnt1 !== 8'h00) begin
      errors++;
      $display("FAIL stats: got cnt0=%h cnt1=%h, required cnt0=%h cnt1=00", cnt0, cnt1, exp_c0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stats_sb: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 8'h00; req0_amt = 3'd0; req0_lr = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_amt = 3'd0; req1_lr = 1'b0;
    last_gnt = 1'b0; nacc = 0;
    @(posedge clk); #1;
    test_reset();
    test_rotate();
    test_alternate();
    test_stall();
    test_back_to_back();
    test_reset_full();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
